// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto processor front end.
// Holds the block geometry, the full PKCS#7 pad block and the loader state encoding.
package crypto_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int MAX_BLOCKS = 1024;
    localparam int CNT_W      = 16;

    localparam logic [BLOCK_SIZE-1:0] PAD_FULL_BLOCK = 64'h0808080808080808;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_PAD,
        ST_START,
        ST_WAIT_DONE,
        ST_DRAIN
    } loader_state_e;

    // A byte count of 0 or above 8 means the whole word is valid.
    function automatic logic [3:0] norm_k(input logic [3:0] k);
        return (k == 4'd0 || k > 4'd8) ? 4'd8 : k;
    endfunction

endpackage

// File: rtl/pkcs7_pad.sv
// Combinational PKCS#7 padder for one 64-bit word (byte 0 = bits [63:56]).
// Ports: word_i (raw word), k_i (valid bytes, 0/>8 = 8), word_o (padded word).
module pkcs7_pad
    import crypto_pkg::*;
(
    input  logic [BLOCK_SIZE-1:0] word_i,
    input  logic [3:0]            k_i,
    output logic [BLOCK_SIZE-1:0] word_o
);

    logic [3:0] kn;
    logic [7:0] pad_byte;

    always_comb begin
        kn       = norm_k(k_i);
        pad_byte = {4'd0, 4'd8 - kn};
        word_o   = word_i;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= kn) begin
                word_o[BLOCK_SIZE-1-8*i -: 8] = pad_byte;
            end
        end
    end

endmodule

// File: rtl/block_loader.sv
// Packs a valid/ready stream of 64-bit words into the processor's flat
// plaintext buffer, applies PKCS#7 padding, pulses start and waits for done.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_data/in_last/
// in_bytes (input stream); plaintext, num_blocks, start (to processor);
// done (from processor); busy, overflow (status).
module block_loader #(
    parameter int MAX_BLOCKS = crypto_pkg::MAX_BLOCKS,
    parameter int CNT_W      = crypto_pkg::CNT_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [crypto_pkg::BLOCK_SIZE-1:0]      in_data,
    input  logic                                   in_last,
    input  logic [3:0]                             in_bytes,
    output logic [crypto_pkg::BLOCK_SIZE*MAX_BLOCKS-1:0] plaintext,
    output logic [CNT_W-1:0]                       num_blocks,
    output logic                                   start,
    input  logic                                   done,
    output logic                                   busy,
    output logic                                   overflow
);

    import crypto_pkg::*;

    localparam int BW = BLOCK_SIZE;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_BLOCKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BLOCKS - 1);

    loader_state_e state_q, state_d;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q, rdy_d;

    logic [BW*MAX_BLOCKS-1:0] buf_q;

    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic [BW-1:0]    wr_data;
    logic [BW-1:0]    padded;
    logic [3:0]       k;
    logic             xfer;

    pkcs7_pad u_pad (
        .word_i (in_data),
        .k_i    (in_bytes),
        .word_o (padded)
    );

    assign k    = norm_k(in_bytes);
    assign xfer = in_valid & rdy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else if (wr_en) begin
            buf_q[int'(wr_idx)*BW +: BW] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        num_d   = num_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = count_q;
        wr_data = in_data;

        unique case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    busy_d = 1'b1;
                    // First word of a new frame clears last frame's overflow.
                    if (count_q == '0) begin
                        ovf_d = 1'b0;
                    end
                    if (count_q == FULL) begin
                        ovf_d = 1'b1;
                        if (in_last) begin
                            count_d = '0;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (!in_last) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE;
                    end else if (k != 4'd8) begin
                        wr_en   = 1'b1;
                        wr_data = padded;
                        num_d   = count_q + ONE;
                        state_d = ST_START;
                    end else if (count_q == LAST) begin
                        // Full last word but no slot left for the pad block.
                        ovf_d   = 1'b1;
                        count_d = '0;
                        busy_d  = 1'b0;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                wr_en   = 1'b1;
                wr_idx  = count_q + ONE;
                wr_data = PAD_FULL_BLOCK;
                num_d   = count_q + TWO;
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (xfer && in_last) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Ready is registered so it is low throughout reset.
        rdy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    assign in_ready   = rdy_q;
    assign plaintext  = buf_q;
    assign num_blocks = num_q;
    assign start      = (state_q == ST_START);
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_block_loader.sv
// Scoreboard bench for block_loader built with a 4-block buffer.
// Expected frames are queued at the handshake and checked when start pulses.
module tb_block_loader;

    localparam int NB = 4;

    typedef struct packed {
        int unsigned      at;
        logic [15:0]      nb;
        logic [3:0]       mask;
        logic [3:0][63:0] blk;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [63:0]    in_data = '0;
    logic           in_last = 1'b0;
    logic [3:0]     in_bytes = '0;
    logic [64*NB-1:0] plaintext;
    logic [15:0]    num_blocks;
    logic           start;
    logic           done = 1'b0;
    logic           busy;
    logic           overflow;

    int unsigned cyc = 0;
    int cmp = 0;
    int mism = 0;
    exp_t q[$];

    localparam logic [63:0] PADB = 64'h0808080808080808;

    block_loader #(.MAX_BLOCKS(NB), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .plaintext  (plaintext),
        .num_blocks (num_blocks),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] req);
        cmp++;
        if (act !== req) begin
            mism++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int unsigned off, input int nbk,
                                input logic [3:0] m, input logic [63:0] b0,
                                input logic [63:0] b1, input logic [63:0] b2,
                                input logic [63:0] b3);
        exp_t e;
        e.at   = off;
        e.nb   = 16'(nbk);
        e.mask = m;
        e.blk  = {b3, b2, b1, b0};
        return e;
    endfunction

    // Monitor: every start pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (!reset && start) begin
            chk("start_expected", 256'(q.size() != 0), 256'(1));
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("start_cycle", 256'(cyc), 256'(e.at));
                chk("num_blocks", 256'(num_blocks), 256'(e.nb));
                chk("busy_at_start", 256'(busy), 256'(1));
                for (int i = 0; i < 4; i++) begin
                    if (e.mask[i]) begin
                        chk($sformatf("block%0d", i),
                            256'(plaintext[i*64 +: 64]), 256'(e.blk[i]));
                    end
                end
            end
        end
    end

    // Offset in e.at is relative to the handshake edge.
    task automatic send(input logic [63:0] d, input logic last,
                        input logic [3:0] b, input bit push, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_xfer", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        if (push) begin
            e.at = cyc + e.at;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 256'(start), 256'(1));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        chk("wait_ready_low", 256'(in_ready), 256'(0));
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        e = '0;

        // Reset values while reset is held.
        #12;
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_start", 256'(start), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_num_blocks", 256'(num_blocks), 256'(0));
        chk("rst_plaintext", 256'(plaintext), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("load_ready", 256'(in_ready), 256'(1));

        // Two full words: pad block appended, start one cycle later.
        send(64'hA5A5A5A5A5A5A5A5, 1'b0, 4'd0, 1'b0, e);
        chk("busy_first_word", 256'(busy), 256'(1));
        send(64'h1122334455667788, 1'b1, 4'd8, 1'b1,
             mk(1, 3, 4'b0111, 64'hA5A5A5A5A5A5A5A5,
                64'h1122334455667788, PADB, 64'h0));
        wait_start();

        // Backpressure in WAIT_DONE, then a short word lands in block 0.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        in_last  = 1'b1;
        in_bytes = 4'd3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", 256'(in_ready), 256'(0));
            chk("bp_plaintext_hold", 256'(plaintext[191:0]),
                256'({PADB, 64'h1122334455667788, 64'hA5A5A5A5A5A5A5A5}));
            @(negedge clk);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("after_done_ready", 256'(in_ready), 256'(1));
        chk("after_done_busy", 256'(busy), 256'(0));
        chk("after_done_nb_kept", 256'(num_blocks), 256'(3));
        @(posedge clk);
        #1;
        e = mk(0, 1, 4'b0001, 64'h0123450505050505, 64'h0, 64'h0, 64'h0);
        e.at = cyc;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_start();
        pulse_done();

        // Overflow: five words then the last one, no start.
        for (int i = 0; i < 5; i++) begin
            send(64'h1000 + 64'(i), 1'b0, 4'd0, 1'b0, e);
        end
        chk("ovf_set", 256'(overflow), 256'(1));
        chk("drain_ready", 256'(in_ready), 256'(1));
        chk("drain_busy", 256'(busy), 256'(1));
        send(64'hFFFF, 1'b1, 4'd3, 1'b0, e);
        chk("ovf_sticky", 256'(overflow), 256'(1));
        chk("ovf_busy_clear", 256'(busy), 256'(0));
        chk("ovf_ready", 256'(in_ready), 256'(1));
        chk("ovf_nb_kept", 256'(num_blocks), 256'(1));
        chk("ovf_block0", 256'(plaintext[63:0]), 256'(64'h1000));

        // Four words, full last word: no room for the pad block.
        send(64'h2000, 1'b0, 4'd0, 1'b0, e);
        chk("ovf_cleared", 256'(overflow), 256'(0));
        chk("count_reset_block0", 256'(plaintext[63:0]), 256'(64'h2000));
        send(64'h2001, 1'b0, 4'd0, 1'b0, e);
        send(64'h2002, 1'b0, 4'd0, 1'b0, e);
        send(64'h2003, 1'b1, 4'd8, 1'b0, e);
        chk("nopad_ovf", 256'(overflow), 256'(1));
        chk("nopad_busy", 256'(busy), 256'(0));
        chk("nopad_ready", 256'(in_ready), 256'(1));
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame.
        send(64'h3000, 1'b0, 4'd0, 1'b0, e);
        send(64'h3001, 1'b0, 4'd0, 1'b0, e);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_plaintext", 256'(plaintext), 256'(0));
        chk("mid_rst_nb", 256'(num_blocks), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_ovf", 256'(overflow), 256'(0));
        chk("mid_rst_ready", 256'(in_ready), 256'(0));
        chk("mid_rst_start", 256'(start), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(64'hFEDCBA9876543210, 1'b1, 4'd5, 1'b1,
             mk(0, 1, 4'b0001, 64'hFEDCBA9876030303, 64'h0, 64'h0, 64'h0));
        wait_start();
        pulse_done();

        // in_bytes=0 behaves as a full word.
        send(64'h0F1E2D3C4B5A6978, 1'b1, 4'd0, 1'b1,
             mk(1, 2, 4'b0011, 64'h0F1E2D3C4B5A6978, PADB, 64'h0, 64'h0));
        wait_start();
        pulse_done();

        // Single valid byte.
        send(64'hAABBCCDDEEFF0011, 1'b1, 4'd1, 1'b1,
             mk(0, 1, 4'b0001, 64'hAA07070707070707, 64'h0, 64'h0, 64'h0));
        wait_start();
        pulse_done();

        repeat (3) @(negedge clk);
        chk("queue_drained", 256'(q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
